// File: rtl/codec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codec_pkg
// Description : Shared constants and types for the I2S record-path receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package codec_pkg;

    localparam int SAMPLE_WIDTH_DEF = 24;
    localparam int BIT_CNT_W        = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_LEFT  = 2'd2,
        ST_RIGHT = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic [SAMPLE_WIDTH_DEF-1:0] left;
        logic [SAMPLE_WIDTH_DEF-1:0] right;
    } stereo_frame_t;

endpackage
`default_nettype wire

// File: rtl/i2s_pin_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pin_sync
// Description : Multi-flop synchronizer for one asynchronous pin, plus a
//               history flop for rising-edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_pin_sync
    import codec_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/codec_i2s_rx.sv
`default_nettype none
// ============================================================================
// Module      : codec_i2s_rx
// Description : I2S record receiver; assembles {left,right} frames from an
//               asynchronous CODEC bit stream. Optional peak meters are built
//               when CODEC_I2S_RX_PEAK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module codec_i2s_rx
    import codec_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                      board_clk,
    input  logic                      reset,
    input  logic                      i2s_bclk,
    input  logic                      i2s_lrclk,
    input  logic                      i2s_sdata,
    input  logic                      enable,
    output logic [2*SAMPLE_WIDTH-1:0] sample_data,
    output logic                      sample_valid,
    input  logic                      sample_ready,
    output logic                      overflow,
    output logic                      frame_error,
    input  logic                      clear_status
`ifdef CODEC_I2S_RX_PEAK_EN
    ,
    input  logic                      peak_clear,
    output logic [SAMPLE_WIDTH-1:0]   peak_left,
    output logic [SAMPLE_WIDTH-1:0]   peak_right
`endif
);

    localparam logic [BIT_CNT_W-1:0] c_cnt_full = BIT_CNT_W'(SAMPLE_WIDTH);

    logic w_bclk_rise, w_lr, w_sd;
    logic w_unused_bclk_level, w_unused_lr_rise, w_unused_sd_rise;

    rx_state_e                 r_state, w_state_nxt;
    logic                      r_lr_last;
    logic [BIT_CNT_W-1:0]      r_bit_cnt;
    logic [SAMPLE_WIDTH-1:0]   r_shift, r_left;
    logic                      r_left_ok, r_done;
    logic [2*SAMPLE_WIDTH-1:0] r_done_data, r_data;
    logic                      r_valid, r_overflow, r_frame_error;
    logic                      w_boundary, w_cnt_full, w_latch_left, w_complete, w_chan_err, w_load;

    i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk(board_clk), .rst(reset), .i_pin(i2s_bclk),
        .o_level(w_unused_bclk_level), .o_rise(w_bclk_rise));
    i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk(board_clk), .rst(reset), .i_pin(i2s_lrclk),
        .o_level(w_lr), .o_rise(w_unused_lr_rise));
    i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk(board_clk), .rst(reset), .i_pin(i2s_sdata),
        .o_level(w_sd), .o_rise(w_unused_sd_rise));

    always_ff @(posedge board_clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_latch_left = 1'b0;
        w_complete   = 1'b0;
        w_chan_err   = 1'b0;
        w_boundary   = w_bclk_rise && (w_lr != r_lr_last);
        w_cnt_full   = (r_bit_cnt >= c_cnt_full);
        case (r_state)
            ST_IDLE:  if (enable) w_state_nxt = ST_HUNT;
            ST_HUNT:  if (w_boundary && !w_lr) w_state_nxt = ST_LEFT;
            ST_LEFT: begin
                if (w_boundary && w_lr) begin
                    w_state_nxt  = ST_RIGHT;
                    w_latch_left = w_cnt_full;
                    w_chan_err   = !w_cnt_full;
                end
            end
            ST_RIGHT: begin
                if (w_boundary && !w_lr) begin
                    w_state_nxt = ST_LEFT;
                    w_complete  = w_cnt_full && r_left_ok;
                    w_chan_err  = !w_cnt_full;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (!enable) begin
            w_state_nxt  = ST_IDLE;
            w_latch_left = 1'b0;
            w_complete   = 1'b0;
            w_chan_err   = 1'b0;
        end
    end

    assign w_load = r_done && (!r_valid || sample_ready);

    always_ff @(posedge board_clk) begin
        if (reset) begin
            r_lr_last     <= 1'b0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_left        <= '0;
            r_left_ok     <= 1'b0;
            r_done        <= 1'b0;
            r_done_data   <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_overflow    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            // lrclk history is tracked even while idle so enabling mid-slot
            // does not fabricate a boundary.
            if (w_bclk_rise) r_lr_last <= w_lr;

            if (r_state == ST_IDLE || !enable) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_left    <= '0;
                r_left_ok <= 1'b0;
            end else if (w_bclk_rise) begin
                if (w_boundary) begin
                    r_bit_cnt <= '0;
                    r_shift   <= '0;
                end else if (!w_cnt_full) begin
                    r_shift   <= {r_shift[SAMPLE_WIDTH-2:0], w_sd};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            if (w_latch_left) begin
                r_left    <= r_shift;
                r_left_ok <= 1'b1;
            end else if (w_chan_err && r_state == ST_LEFT) begin
                r_left_ok <= 1'b0;
            end

            r_done <= w_complete;
            if (w_complete) r_done_data <= {r_left, r_shift};

            if (w_load) begin
                r_data  <= r_done_data;
                r_valid <= 1'b1;
            end else if (r_valid && sample_ready) begin
                r_valid <= 1'b0;
            end

            if (r_done && !w_load) r_overflow <= 1'b1;
            else if (clear_status) r_overflow <= 1'b0;

            if (w_chan_err)        r_frame_error <= 1'b1;
            else if (clear_status) r_frame_error <= 1'b0;
        end
    end

    assign sample_data  = r_data;
    assign sample_valid = r_valid;
    assign overflow     = r_overflow;
    assign frame_error  = r_frame_error;

`ifdef CODEC_I2S_RX_PEAK_EN
    localparam logic [SAMPLE_WIDTH-1:0] c_most_neg = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    localparam logic [SAMPLE_WIDTH-1:0] c_pos_max  = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};

    function automatic logic [SAMPLE_WIDTH-1:0] sat_abs(input logic [SAMPLE_WIDTH-1:0] s);
        if (s == c_most_neg)       return c_pos_max;
        else if (s[SAMPLE_WIDTH-1]) return -s;
        else                       return s;
    endfunction

    logic [SAMPLE_WIDTH-1:0] w_abs_l, w_abs_r, r_peak_l, r_peak_r;

    assign w_abs_l = sat_abs(r_done_data[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH]);
    assign w_abs_r = sat_abs(r_done_data[SAMPLE_WIDTH-1:0]);

    always_ff @(posedge board_clk) begin
        if (reset) begin
            r_peak_l <= '0;
            r_peak_r <= '0;
        end else if (w_load) begin
            if (w_abs_l > r_peak_l) r_peak_l <= w_abs_l;
            if (w_abs_r > r_peak_r) r_peak_r <= w_abs_r;
        end else if (peak_clear) begin
            r_peak_l <= '0;
            r_peak_r <= '0;
        end
    end

    assign peak_left  = r_peak_l;
    assign peak_right = r_peak_r;
`endif

endmodule
`default_nettype wire
